// File: rtl/muon_pulse_detector_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muon_pulse_detector_if
// Purpose  : ADC sample stream plus valid/ready event port of the pulse detector.
// Revision : 1.0
// ============================================================================
interface muon_pulse_detector_if #(
  parameter int TS_W = 32
);
  logic [7:0]      adc_data;
  logic            adc_valid;
  logic            evt_valid;
  logic            evt_ready;
  logic [7:0]      evt_peak;
  logic [7:0]      evt_width;
  logic [15:0]     evt_area;
  logic [TS_W-1:0] evt_time;
  logic            evt_trunc;

  modport master (
    output adc_data, adc_valid, evt_ready,
    input  evt_valid, evt_peak, evt_width, evt_area, evt_time, evt_trunc
  );

  modport slave (
    input  adc_data, adc_valid, evt_ready,
    output evt_valid, evt_peak, evt_width, evt_area, evt_time, evt_trunc
  );
endinterface
`default_nettype wire

// File: rtl/muon_pulse_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muon_pulse_detector
// Purpose  : Baseline-tracking pulse extractor for the flash ADC stream; measures
//            peak/width/area and presents one timestamped event at a time.
// Revision : 1.0
// ============================================================================
module muon_pulse_detector #(
  parameter int THRESH  = 20,
  parameter int WARMUP  = 128,
  parameter int HOLDOFF = 16,
  parameter int MAX_LEN = 255,
  parameter int TS_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  muon_pulse_detector_if.slave bus,
  output logic [7:0]           baseline,
  output logic                 armed,
  output logic [15:0]          dropped_cnt
);

  localparam int CNT_MAX = (WARMUP > HOLDOFF) ? WARMUP : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] C_WARMUP_LAST  = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] C_HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [7:0]       C_THRESH       = 8'(THRESH);
  localparam logic [7:0]       C_MAX_LEN      = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_WARMUP  = 3'd0,
    S_IDLE    = 3'd1,
    S_PULSE   = 3'd2,
    S_EMIT    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t          state_q,     state_d;
  logic [TS_W-1:0] ts_q,        ts_d;
  logic [10:0]     acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic            armed_q,     armed_d;
  logic [15:0]     dropped_q,   dropped_d;

  // Pulse under construction
  logic [7:0]      p_peak_q,    p_peak_d;
  logic [7:0]      p_width_q,   p_width_d;
  logic [15:0]     p_area_q,    p_area_d;
  logic [TS_W-1:0] p_time_q,    p_time_d;
  logic            p_trunc_q,   p_trunc_d;

  // Event presented downstream
  logic            evt_valid_q, evt_valid_d;
  logic [7:0]      evt_peak_q,  evt_peak_d;
  logic [7:0]      evt_width_q, evt_width_d;
  logic [15:0]     evt_area_q,  evt_area_d;
  logic [TS_W-1:0] evt_time_q,  evt_time_d;
  logic            evt_trunc_q, evt_trunc_d;

  logic [7:0]  base;
  logic [7:0]  amp;
  logic        above;
  logic        accept;
  logic [10:0] acc_upd;

  always_comb begin
    base    = acc_q[10:3];
    amp     = (bus.adc_data > base) ? (bus.adc_data - base) : 8'd0;
    above   = (amp >= C_THRESH);
    // acc - acc/8 + sample stays within 11 bits for any 8-bit sample
    acc_upd = acc_q + {3'b000, bus.adc_data} - {3'b000, base};
    accept  = evt_valid_q & bus.evt_ready;
  end

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q + 1'b1;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    dropped_d   = dropped_q;
    p_peak_d    = p_peak_q;
    p_width_d   = p_width_q;
    p_area_d    = p_area_q;
    p_time_d    = p_time_q;
    p_trunc_d   = p_trunc_q;
    evt_valid_d = accept ? 1'b0 : evt_valid_q;
    evt_peak_d  = evt_peak_q;
    evt_width_d = evt_width_q;
    evt_area_d  = evt_area_q;
    evt_time_d  = evt_time_q;
    evt_trunc_d = evt_trunc_q;

    case (state_q)
      S_WARMUP: begin
        if (bus.adc_valid) begin
          acc_d = (cnt_q == '0) ? {bus.adc_data, 3'b000} : acc_upd;
          if (cnt_q == C_WARMUP_LAST) begin
            state_d = S_IDLE;
            armed_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (bus.adc_valid) begin
          if (above) begin
            p_time_d  = ts_q;
            p_peak_d  = amp;
            p_area_d  = {8'd0, amp};
            p_width_d = 8'd1;
            p_trunc_d = (C_MAX_LEN == 8'd1);
            state_d   = (C_MAX_LEN == 8'd1) ? S_EMIT : S_PULSE;
          end else begin
            acc_d = acc_upd;
          end
        end
      end

      S_PULSE: begin
        if (bus.adc_valid) begin
          if (above) begin
            p_width_d = p_width_q + 8'd1;
            p_area_d  = p_area_q + {8'd0, amp};
            p_peak_d  = (amp > p_peak_q) ? amp : p_peak_q;
            if (p_width_q + 8'd1 == C_MAX_LEN) begin
              p_trunc_d = 1'b1;
              state_d   = S_EMIT;
            end
          end else begin
            state_d = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        // A held event that is being accepted this cycle frees the slot for the new one
        if (!evt_valid_q || accept) begin
          evt_valid_d = 1'b1;
          evt_peak_d  = p_peak_q;
          evt_width_d = p_width_q;
          evt_area_d  = p_area_q;
          evt_time_d  = p_time_q;
          evt_trunc_d = p_trunc_q;
        end else if (dropped_q != 16'hFFFF) begin
          dropped_d = dropped_q + 16'd1;
        end
        cnt_d   = '0;
        state_d = S_HOLDOFF;
      end

      S_HOLDOFF: begin
        if (bus.adc_valid) begin
          if (cnt_q == C_HOLDOFF_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_WARMUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WARMUP;
      ts_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      dropped_q   <= '0;
      p_peak_q    <= '0;
      p_width_q   <= '0;
      p_area_q    <= '0;
      p_time_q    <= '0;
      p_trunc_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_peak_q  <= '0;
      evt_width_q <= '0;
      evt_area_q  <= '0;
      evt_time_q  <= '0;
      evt_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      dropped_q   <= dropped_d;
      p_peak_q    <= p_peak_d;
      p_width_q   <= p_width_d;
      p_area_q    <= p_area_d;
      p_time_q    <= p_time_d;
      p_trunc_q   <= p_trunc_d;
      evt_valid_q <= evt_valid_d;
      evt_peak_q  <= evt_peak_d;
      evt_width_q <= evt_width_d;
      evt_area_q  <= evt_area_d;
      evt_time_q  <= evt_time_d;
      evt_trunc_q <= evt_trunc_d;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_peak  = evt_peak_q;
  assign bus.evt_width = evt_width_q;
  assign bus.evt_area  = evt_area_q;
  assign bus.evt_time  = evt_time_q;
  assign bus.evt_trunc = evt_trunc_q;
  assign baseline      = acc_q[10:3];
  assign armed         = armed_q;
  assign dropped_cnt   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_muon_pulse_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_muon_pulse_detector
// Purpose  : Directed and randomized checks of muon_pulse_detector against a
//            sample-level reference model.
// Revision : 1.0
// ============================================================================
module tb_muon_pulse_detector;

  localparam int TS_W = 32;

  typedef struct packed {
    logic [7:0]  peak;
    logic [7:0]  width;
    logic [15:0] area;
    logic [31:0] t;
    logic        trunc;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  baseline;
  logic        armed;
  logic [15:0] dropped_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  muon_pulse_detector_if #(.TS_W(TS_W)) bus ();

  muon_pulse_detector #(
    .THRESH (20),
    .WARMUP (128),
    .HOLDOFF(16),
    .MAX_LEN(255),
    .TS_W   (TS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .baseline   (baseline),
    .armed      (armed),
    .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: tracks samples, the pulse being measured and the presented event
  int          m_warm;
  int          m_acc;
  int          m_hold;
  bit          m_in_pulse;
  bit          m_emit;
  evt_t        m_cur;
  evt_t        m_out;
  bit          m_out_valid;
  int          m_drop;
  logic [31:0] cyc;

  evt_t obs[$];

  task automatic model_reset();
    m_warm = 0; m_acc = 0; m_hold = 0; m_in_pulse = 0; m_emit = 0;
    m_cur = '0; m_out = '0; m_out_valid = 0; m_drop = 0; cyc = 0;
  endtask

  task automatic model_sample(input int d);
    int base, amp;
    base = m_acc / 8;
    amp  = (d > base) ? d - base : 0;
    if (m_warm < 128) begin
      m_acc = (m_warm == 0) ? d * 8 : (m_acc + d - base) % 2048;
      m_warm++;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_in_pulse) begin
      if (amp >= 20) begin
        m_cur.width = m_cur.width + 8'd1;
        m_cur.area  = m_cur.area + 16'(amp);
        if (amp > int'(m_cur.peak)) m_cur.peak = 8'(amp);
        if (m_cur.width == 8'd255) begin
          m_cur.trunc = 1'b1; m_in_pulse = 0; m_emit = 1;
        end
      end else begin
        m_in_pulse = 0; m_emit = 1;
      end
    end else if (amp >= 20) begin
      m_in_pulse  = 1;
      m_cur.peak  = 8'(amp);
      m_cur.width = 8'd1;
      m_cur.area  = 16'(amp);
      m_cur.t     = cyc;
      m_cur.trunc = 1'b0;
    end else begin
      m_acc = (m_acc + d - base) % 2048;
    end
  endtask

  task automatic model_clock();
    bit acc;
    acc = m_out_valid && bus.evt_ready;
    if (m_emit) begin
      if (!m_out_valid || acc) begin
        m_out = m_cur; m_out_valid = 1;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
      m_emit = 0;
      m_hold = 16;
    end else begin
      if (acc) m_out_valid = 0;
      if (bus.adc_valid) model_sample(int'(bus.adc_data));
    end
    cyc = cyc + 32'd1;
  endtask

  // One clock: drive at negedge, advance model at posedge, return at next negedge
  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    logic pv, pa;
    evt_t e;
    bus.adc_valid = v;
    bus.adc_data  = d;
    bus.evt_ready = rdy;
    pv = bus.evt_valid;
    pa = pv && rdy;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    if (bus.evt_valid && (!pv || pa)) begin
      e.peak = bus.evt_peak; e.width = bus.evt_width; e.area = bus.evt_area;
      e.t = bus.evt_time; e.trunc = bus.evt_trunc;
      obs.push_back(e);
    end
  endtask

  task automatic test_reset();
    bus.adc_valid = 1'b0; bus.adc_data = 8'd0; bus.evt_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid got %0b want 0", bus.evt_valid); end
    n_checks++; if ({bus.evt_peak, bus.evt_width, bus.evt_area, bus.evt_time, bus.evt_trunc} !== '0) begin n_fail++; $display("FAIL reset_evt_regs got %0h want 0", {bus.evt_peak, bus.evt_width, bus.evt_area, bus.evt_time, bus.evt_trunc}); end
    n_checks++; if ({baseline, armed, dropped_cnt} !== '0) begin n_fail++; $display("FAIL reset_status got %0h want 0", {baseline, armed, dropped_cnt}); end
    rst_n = 1'b1;
  endtask

  task automatic test_warmup();
    obs.delete();
    repeat (127) step(1'b1, 8'd10, 1'b1);
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL warmup_armed_early got %0b want 0", armed); end
    step(1'b1, 8'd10, 1'b1);
    n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL warmup_armed got %0b want 1", armed); end
    n_checks++; if (baseline !== 8'd10) begin n_fail++; $display("FAIL warmup_baseline got %0d want 10", baseline); end
    n_checks++; if (obs.size() != 0) begin n_fail++; $display("FAIL warmup_no_events got %0d want 0", obs.size()); end
  endtask

  task automatic test_basic_pulse();
    logic [31:0] t40;
    obs.delete();
    step(1'b1, 8'd10, 1'b1);
    t40 = cyc;
    step(1'b1, 8'd40, 1'b1);
    step(1'b1, 8'd60, 1'b1);
    step(1'b1, 8'd35, 1'b1);
    step(1'b1, 8'd10, 1'b1);
    step(1'b1, 8'd10, 1'b1);
    n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL basic_latency events got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      n_checks++; if (obs[0].peak !== 8'd50) begin n_fail++; $display("FAIL basic_peak got %0d want 50", obs[0].peak); end
      n_checks++; if (obs[0].width !== 8'd3) begin n_fail++; $display("FAIL basic_width got %0d want 3", obs[0].width); end
      n_checks++; if (obs[0].area !== 16'd105) begin n_fail++; $display("FAIL basic_area got %0d want 105", obs[0].area); end
      n_checks++; if (obs[0].trunc !== 1'b0) begin n_fail++; $display("FAIL basic_trunc got %0b want 0", obs[0].trunc); end
      n_checks++; if (obs[0].t !== t40) begin n_fail++; $display("FAIL basic_time got %0d want %0d", obs[0].t, t40); end
    end
    step(1'b1, 8'd10, 1'b1);
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept got %0b want 0", bus.evt_valid); end
    repeat (20) step(1'b1, 8'd10, 1'b1);
    n_checks++; if (baseline !== 8'd10) begin n_fail++; $display("FAIL basic_baseline got %0d want 10", baseline); end
  endtask

  task automatic test_backpressure();
    obs.delete();
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd50, 1'b0);
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd10, 1'b0);
    n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL bp_first_event events got %0d want 1", obs.size()); end
    repeat (20) step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd70, 1'b0);
    step(1'b1, 8'd70, 1'b0);
    step(1'b1, 8'd10, 1'b0);
    repeat (4) step(1'b1, 8'd10, 1'b0);
    n_checks++; if (dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_dropped got %0d want 1", dropped_cnt); end
    n_checks++; if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid got %0b want 1", bus.evt_valid); end
    n_checks++; if ({bus.evt_peak, bus.evt_width, bus.evt_area} !== {8'd40, 8'd1, 16'd40}) begin n_fail++; $display("FAIL bp_held_data got peak %0d width %0d area %0d want 40 1 40", bus.evt_peak, bus.evt_width, bus.evt_area); end
    step(1'b1, 8'd10, 1'b1);
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %0b want 0", bus.evt_valid); end
    n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL bp_event_count got %0d want 1", obs.size()); end
    repeat (20) step(1'b1, 8'd10, 1'b1);
  endtask

  task automatic test_truncation();
    obs.delete();
    repeat (300) step(1'b1, 8'd100, 1'b1);
    for (int i = 0; i < 10 && obs.size() < 2; i++) step(1'b1, 8'd10, 1'b1);
    n_checks++; if (obs.size() != 2) begin n_fail++; $display("FAIL trunc_events got %0d want 2", obs.size()); end
    if (obs.size() == 2) begin
      n_checks++; if ({obs[0].peak, obs[0].width, obs[0].area, obs[0].trunc} !== {8'd90, 8'd255, 16'd22950, 1'b1}) begin n_fail++; $display("FAIL trunc_first got peak %0d width %0d area %0d trunc %0b want 90 255 22950 1", obs[0].peak, obs[0].width, obs[0].area, obs[0].trunc); end
      n_checks++; if ({obs[1].peak, obs[1].width, obs[1].area, obs[1].trunc} !== {8'd90, 8'd28, 16'd2520, 1'b0}) begin n_fail++; $display("FAIL trunc_second got peak %0d width %0d area %0d trunc %0b want 90 28 2520 0", obs[1].peak, obs[1].width, obs[1].area, obs[1].trunc); end
      n_checks++; if (obs[1].t - obs[0].t !== 32'd272) begin n_fail++; $display("FAIL trunc_retrigger_gap got %0d want 272", obs[1].t - obs[0].t); end
    end
    repeat (20) step(1'b1, 8'd10, 1'b1);
    n_checks++; if (baseline !== 8'd10) begin n_fail++; $display("FAIL trunc_baseline got %0d want 10", baseline); end
  endtask

  task automatic test_gaps();
    logic [7:0]  seq [5];
    logic [31:0] t40;
    seq[0] = 8'd10; seq[1] = 8'd40; seq[2] = 8'd60; seq[3] = 8'd35; seq[4] = 8'd10;
    t40 = '0;
    obs.delete();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) t40 = cyc;
      step(1'b1, seq[i], 1'b1);
      repeat (5) step(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    end
    n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL gaps_events got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      n_checks++; if ({obs[0].peak, obs[0].width, obs[0].area, obs[0].trunc} !== {8'd50, 8'd3, 16'd105, 1'b0}) begin n_fail++; $display("FAIL gaps_event got peak %0d width %0d area %0d trunc %0b want 50 3 105 0", obs[0].peak, obs[0].width, obs[0].area, obs[0].trunc); end
      n_checks++; if (obs[0].t !== t40) begin n_fail++; $display("FAIL gaps_time got %0d want %0d", obs[0].t, t40); end
    end
    repeat (20) step(1'b1, 8'd10, 1'b1);
  endtask

  task automatic test_reset_mid_pulse();
    step(1'b1, 8'd10, 1'b1);
    step(1'b1, 8'd60, 1'b1);
    step(1'b1, 8'd60, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if ({bus.evt_valid, bus.evt_peak, bus.evt_width, bus.evt_area, bus.evt_time, bus.evt_trunc} !== '0) begin n_fail++; $display("FAIL rstmid_evt got %0h want 0", {bus.evt_valid, bus.evt_peak, bus.evt_width, bus.evt_area, bus.evt_time, bus.evt_trunc}); end
    n_checks++; if ({baseline, armed, dropped_cnt} !== '0) begin n_fail++; $display("FAIL rstmid_status got %0h want 0", {baseline, armed, dropped_cnt}); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    obs.delete();
    repeat (127) step(1'b1, 8'd30, 1'b1);
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL rstmid_armed_early got %0b want 0", armed); end
    step(1'b1, 8'd30, 1'b1);
    n_checks++; if ({armed, baseline} !== {1'b1, 8'd30}) begin n_fail++; $display("FAIL rstmid_rearm got armed %0b baseline %0d want 1 30", armed, baseline); end
    n_checks++; if (obs.size() != 0) begin n_fail++; $display("FAIL rstmid_no_events got %0d want 0", obs.size()); end
  endtask

  task automatic test_random();
    int   burst;
    evt_t e;
    int   base_events;
    burst = 0;
    base_events = obs.size();
    for (int i = 0; i < 4000; i++) begin
      logic v, r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      if (burst == 0 && $urandom_range(0, 39) == 0)
        burst = ($urandom_range(0, 14) == 0) ? 300 : int'($urandom_range(1, 8));
      if (burst > 0) begin
        d = 8'($urandom_range(45, 255));
        if (v) burst--;
      end else begin
        d = 8'($urandom_range(28, 33));
      end
      r = (((i / 300) % 2) == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 4) != 0);
      step(v, d, r);
      n_checks++; if (bus.evt_valid !== m_out_valid) begin n_fail++; $display("FAIL rnd_evt_valid cycle %0d got %0b want %0b", i, bus.evt_valid, m_out_valid); end
      if (m_out_valid) begin
        e.peak = bus.evt_peak; e.width = bus.evt_width; e.area = bus.evt_area;
        e.t = bus.evt_time; e.trunc = bus.evt_trunc;
        n_checks++; if (e !== m_out) begin n_fail++; $display("FAIL rnd_evt_data cycle %0d got %0h want %0h", i, e, m_out); end
      end
      n_checks++; if (baseline !== 8'(m_acc / 8)) begin n_fail++; $display("FAIL rnd_baseline cycle %0d got %0d want %0d", i, baseline, m_acc / 8); end
      n_checks++; if (armed !== (m_warm >= 128)) begin n_fail++; $display("FAIL rnd_armed cycle %0d got %0b want %0b", i, armed, m_warm >= 128); end
      n_checks++; if (dropped_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_dropped cycle %0d got %0d want %0d", i, dropped_cnt, m_drop); end
    end
    n_checks++; if (obs.size() - base_events < 10) begin n_fail++; $display("FAIL rnd_activity events got %0d want >=10", obs.size() - base_events); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_basic_pulse();
    test_backpressure();
    test_truncation();
    test_gaps();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
